uart_tx_serializer: RTL and testbench



---
 rtl/uart_tx_serializer.sv | 110 +++++++++++
 tb/tb_uart_tx_serializer.sv | 135 +++++++++++++
 2 files changed

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: accepts a parallel word on a valid/busy handshake and
// shifts out start bit, data bits LSB first, optional even/odd parity, and stop bit.
// Clocked at the bit rate, so one clock period is one bit period.
module uart_tx_serializer #(
   parameter int unsigned DATA_WIDTH = 8
) (
   input  logic                  CLK,
   input  logic                  Reset,
   input  logic [DATA_WIDTH-1:0] P_DATA,
   input  logic                  Data_Valid,
   input  logic                  PAR_EN,
   input  logic                  PAR_TYP,
   output logic                  TX_OUT,
   output logic                  Busy
);

   localparam int unsigned CntW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [CntW-1:0] LastBit = CntW'(DATA_WIDTH - 1);

   typedef enum logic [2:0] {
      StIdle,
      StStart,
      StData,
      StParity,
      StStop
   } state_e;

   state_e                  state_q;
   logic [DATA_WIDTH-1:0]   data_q;
   logic                    par_en_q;
   logic                    par_typ_q;
   logic [CntW-1:0]         cnt_q;
   logic                    tx_q;
   logic                    busy_q;

   logic [CntW-1:0]         cnt_inc;
   logic                    par_bit;

   // Next bit index and parity bit, both derived from the latched frame only.
   always_comb begin
      cnt_inc = cnt_q + CntW'(1);
      // Even parity is the XOR of the data; odd parity inverts it.
      par_bit = (^data_q) ^ par_typ_q;
   end

   // Frame sequencer; TX_OUT and Busy are registered so each state's level appears
   // in the cycle after the edge that enters it.
   always_ff @(posedge CLK or negedge Reset) begin
      if (!Reset) begin
         state_q   <= StIdle;
         data_q    <= '0;
         par_en_q  <= 1'b0;
         par_typ_q <= 1'b0;
         cnt_q     <= '0;
         tx_q      <= 1'b1;
         busy_q    <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (Data_Valid) begin
                  data_q    <= P_DATA;
                  par_en_q  <= PAR_EN;
                  par_typ_q <= PAR_TYP;
                  tx_q      <= 1'b0;
                  busy_q    <= 1'b1;
                  state_q   <= StStart;
               end
            end
            StStart: begin
               cnt_q   <= '0;
               tx_q    <= data_q[0];
               state_q <= StData;
            end
            StData: begin
               if (cnt_q == LastBit) begin
                  if (par_en_q) begin
                     tx_q    <= par_bit;
                     state_q <= StParity;
                  end else begin
                     tx_q    <= 1'b1;
                     state_q <= StStop;
                  end
               end else begin
                  cnt_q <= cnt_inc;
                  tx_q  <= data_q[cnt_inc];
               end
            end
            StParity: begin
               tx_q    <= 1'b1;
               state_q <= StStop;
            end
            StStop: begin
               // Returning to idle forces at least one idle-high cycle between frames.
               tx_q    <= 1'b1;
               busy_q  <= 1'b0;
               state_q <= StIdle;
            end
            default: begin
               tx_q    <= 1'b1;
               busy_q  <= 1'b0;
               state_q <= StIdle;
            end
         endcase
      end
   end

   assign TX_OUT = tx_q;
   assign Busy   = busy_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed bench for uart_tx_serializer: samples on the falling edge and checks
// every transmitted bit and the Busy flag against hand-computed frames.
module tb_uart_tx_serializer;

   logic       CLK;
   logic       Reset;
   logic [7:0] P_DATA;
   logic       Data_Valid;
   logic       PAR_EN;
   logic       PAR_TYP;
   logic       TX_OUT;
   logic       Busy;

   int n_checks;
   int n_fails;

   uart_tx_serializer #(
      .DATA_WIDTH(8)
   ) dut (
      .CLK       (CLK),
      .Reset     (Reset),
      .P_DATA    (P_DATA),
      .Data_Valid(Data_Valid),
      .PAR_EN    (PAR_EN),
      .PAR_TYP   (PAR_TYP),
      .TX_OUT    (TX_OUT),
      .Busy      (Busy)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic obs, input logic exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fails++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   // seq[i] is the i-th bit on the line (start bit first). Checks n bits with Busy
   // high, then the idle cycle that follows with TX_OUT high and Busy low.
   task automatic check_seq(input logic [10:0] seq, input int n, input string tag);
      for (int i = 0; i < n; i++) begin
         chk($sformatf("%s tx[%0d]", tag, i), TX_OUT, seq[i]);
         chk($sformatf("%s busy[%0d]", tag, i), Busy, 1'b1);
         @(negedge CLK);
      end
      chk($sformatf("%s idle tx", tag), TX_OUT, 1'b1);
      chk($sformatf("%s idle busy", tag), Busy, 1'b0);
   endtask

   // Called at a falling edge: presents one-cycle Data_Valid, returns at the falling
   // edge where the start bit should be on the line.
   task automatic start_frame(input logic [7:0] d, input logic pe, input logic pt);
      P_DATA     = d;
      PAR_EN     = pe;
      PAR_TYP    = pt;
      Data_Valid = 1'b1;
      @(negedge CLK);
      Data_Valid = 1'b0;
   endtask

   initial begin
      n_checks   = 0;
      n_fails    = 0;
      Reset      = 1'b0;
      Data_Valid = 1'b1;
      P_DATA     = 8'hA5;
      PAR_EN     = 1'b0;
      PAR_TYP    = 1'b0;

      // Held in reset with Data_Valid high: line idles, nothing accepted.
      for (int i = 0; i < 3; i++) begin
         @(negedge CLK);
         chk("reset tx", TX_OUT, 1'b1);
         chk("reset busy", Busy, 1'b0);
      end

      // Release; first edge with Data_Valid accepts. 0xA5 no parity.
      Reset = 1'b1;
      start_frame(8'hA5, 1'b0, 1'b0);
      check_seq(11'b0_1_10100101_0, 10, "a5_nopar");

      // 0xA5 even parity (four ones -> 0), then odd parity (-> 1).
      start_frame(8'hA5, 1'b1, 1'b0);
      check_seq(11'b1_0_10100101_0, 11, "a5_even");
      start_frame(8'hA5, 1'b1, 1'b1);
      check_seq(11'b1_1_10100101_0, 11, "a5_odd");

      // 0x03 odd parity; inputs changed right after accept must not matter.
      start_frame(8'h03, 1'b1, 1'b1);
      P_DATA  = 8'hFF;
      PAR_TYP = 1'b0;
      check_seq(11'b1_1_00000011_0, 11, "03_odd_live_change");

      // Data_Valid held high: back-to-back 0x55 frames, one idle cycle between.
      @(negedge CLK);
      P_DATA     = 8'h55;
      PAR_EN     = 1'b0;
      PAR_TYP    = 1'b0;
      Data_Valid = 1'b1;
      @(negedge CLK);
      check_seq(11'b0_1_01010101_0, 10, "55_frame1");
      @(negedge CLK);
      check_seq(11'b0_1_01010101_0, 10, "55_frame2");
      Data_Valid = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(negedge CLK);
         chk("after_stream tx", TX_OUT, 1'b1);
         chk("after_stream busy", Busy, 1'b0);
      end

      // Reset pulsed during data bit 3 of an 0xA5 frame.
      start_frame(8'hA5, 1'b0, 1'b0);
      repeat (4) @(negedge CLK);
      chk("midframe d3 tx", TX_OUT, 1'b0);
      chk("midframe d3 busy", Busy, 1'b1);
      #2 Reset = 1'b0;
      #1;
      chk("async reset tx", TX_OUT, 1'b1);
      chk("async reset busy", Busy, 1'b0);
      @(negedge CLK);
      Reset = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge CLK);
         chk("post_reset tx", TX_OUT, 1'b1);
         chk("post_reset busy", Busy, 1'b0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
